// File: rtl/mpram_chk_pkg.sv
// Shared definitions for the multi-read-port RAM interface checker.
//   lanes()       : number of byte lanes in a data word
//   RdwOld/RdwNew : read-during-write expectation modes
//   PortIdxWidth  : width of the reported first-error port index
package mpram_chk_pkg;

  localparam int unsigned RdwOld       = 0;
  localparam int unsigned RdwNew       = 1;
  localparam int unsigned PortIdxWidth = 3;

  function automatic int unsigned lanes(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mpram_chk_rd_lane.sv
// One read port of the checker: delays the issue-time expectation by RD_LATENCY cycles,
// then compares it with the returned data lane by lane and registers the result strobes.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   issue, issue_addr/exp/mask     read strobe and shadow capture taken at issue
//   rd_data, ecccorr, eccderr      returned data and ECC flags (sampled at issue+RD_LATENCY)
//   mismatch, unwritten, corr, derr  one-cycle result strobes
//   chk_addr, chk_exp, chk_got     details of the compared read, valid with the strobes
module mpram_chk_rd_lane import mpram_chk_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue,
  input  logic [ADDR_WIDTH-1:0]   issue_addr,
  input  logic [DATA_WIDTH-1:0]   issue_exp,
  input  logic [DATA_WIDTH/8-1:0] issue_mask,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    ecccorr,
  input  logic                    eccderr,
  output logic                    mismatch,
  output logic                    unwritten,
  output logic                    corr,
  output logic                    derr,
  output logic [ADDR_WIDTH-1:0]   chk_addr,
  output logic [DATA_WIDTH-1:0]   chk_exp,
  output logic [DATA_WIDTH-1:0]   chk_got
);

  localparam int unsigned Lanes = lanes(DATA_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp;
    logic [Lanes-1:0]      mask;
  } rd_entry_t;

  rd_entry_t             pipe_q [RD_LATENCY];
  rd_entry_t             tail;
  logic [DATA_WIDTH-1:0] lane_bits;
  logic                  diff;

  assign tail = pipe_q[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: issue, addr: issue_addr, exp: issue_exp, mask: issue_mask};
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    lane_bits = '0;
    for (int l = 0; l < int'(Lanes); l++) lane_bits[l*8 +: 8] = {8{tail.mask[l]}};
  end

  assign diff = |((rd_data ^ tail.exp) & lane_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch  <= 1'b0;
      unwritten <= 1'b0;
      corr      <= 1'b0;
      derr      <= 1'b0;
    end else begin
      // A double error makes the data meaningless, so it suppresses the compare.
      mismatch  <= tail.valid && !eccderr && (tail.mask != '0) && diff;
      unwritten <= tail.valid && !eccderr && (tail.mask == '0);
      corr      <= tail.valid && ecccorr;
      derr      <= tail.valid && eccderr;
    end
  end

  // Unwritten lanes report as zero so the capture never exposes stale shadow bytes.
  always_ff @(posedge clk) begin
    chk_addr <= tail.addr;
    chk_exp  <= tail.exp & lane_bits;
    chk_got  <= rd_data;
  end

endmodule

// File: rtl/mpram_intf_checker.sv
// Snooping checker for a multi-read-port RAM with byte-lane writes. Holds a shadow copy with
// per-lane valid bits, re-times each read through mpram_chk_rd_lane, and reports results.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   wr_cs, wr_addr, wr_be, wr_data      snooped write port
//   rd_cs, rd_addr, rd_data             snooped read ports (packed, port 0 in LSBs)
//   ecccorr, eccderr                    per-port ECC flags, qualified with rd_data
//   clear_mem, clr_stats                invalidate shadow / clear statistics
//   err_mismatch, err_unwritten         per-port one-cycle error pulses
//   err_sticky                          latched any-error flag
//   *_cnt                               saturating event counters
//   first_err_*                         capture of the first mismatch
module mpram_intf_checker import mpram_chk_pkg::*; #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned RDW_NEW      = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_cs,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [DATA_WIDTH/8-1:0]             wr_be,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [NUM_RD_PORTS-1:0]             rd_cs,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  rd_addr,
  input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]  rd_data,
  input  logic [NUM_RD_PORTS-1:0]             ecccorr,
  input  logic [NUM_RD_PORTS-1:0]             eccderr,
  input  logic                                clear_mem,
  input  logic                                clr_stats,
  output logic [NUM_RD_PORTS-1:0]             err_mismatch,
  output logic [NUM_RD_PORTS-1:0]             err_unwritten,
  output logic                                err_sticky,
  output logic [CNT_WIDTH-1:0]                mismatch_cnt,
  output logic [CNT_WIDTH-1:0]                unwritten_cnt,
  output logic [CNT_WIDTH-1:0]                ecccorr_cnt,
  output logic [CNT_WIDTH-1:0]                eccderr_cnt,
  output logic                                first_err_valid,
  output logic [PortIdxWidth-1:0]             first_err_port,
  output logic [ADDR_WIDTH-1:0]               first_err_addr,
  output logic [DATA_WIDTH-1:0]               first_err_exp,
  output logic [DATA_WIDTH-1:0]               first_err_got
);

  localparam int unsigned Lanes = lanes(DATA_WIDTH);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Lanes-1:0]      vld_q [Depth];

  logic [NUM_RD_PORTS-1:0] mis_s, unw_s, corr_s, derr_s;
  logic [ADDR_WIDTH-1:0]   chk_addr [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]   chk_exp  [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]   chk_got  [NUM_RD_PORTS];

  // Shadow data needs no reset: lanes are only trusted through vld_q.
  always_ff @(posedge clk) begin
    if (wr_cs) begin
      for (int l = 0; l < int'(Lanes); l++) begin
        if (wr_be[l]) mem_q[wr_addr][l*8 +: 8] <= wr_data[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) vld_q[i] <= '0;
    end else begin
      if (clear_mem) begin
        for (int i = 0; i < int'(Depth); i++) vld_q[i] <= '0;
      end
      // Later assignment wins, so a same-cycle write survives clear_mem.
      if (wr_cs) vld_q[wr_addr] <= clear_mem ? wr_be : (vld_q[wr_addr] | wr_be);
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [Lanes-1:0]      exp_mask;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      exp_data = mem_q[addr];
      exp_mask = vld_q[addr];
      if (RDW_NEW == RdwNew && wr_cs && wr_addr == addr) begin
        for (int l = 0; l < int'(Lanes); l++) begin
          if (wr_be[l]) exp_data[l*8 +: 8] = wr_data[l*8 +: 8];
        end
        exp_mask = exp_mask | wr_be;
      end
    end

    mpram_chk_rd_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_rd_lane (
      .clk        (clk),
      .rst        (rst),
      .issue      (rd_cs[p]),
      .issue_addr (addr),
      .issue_exp  (exp_data),
      .issue_mask (exp_mask),
      .rd_data    (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .ecccorr    (ecccorr[p]),
      .eccderr    (eccderr[p]),
      .mismatch   (mis_s[p]),
      .unwritten  (unw_s[p]),
      .corr       (corr_s[p]),
      .derr       (derr_s[p]),
      .chk_addr   (chk_addr[p]),
      .chk_exp    (chk_exp[p]),
      .chk_got    (chk_got[p])
    );
  end

  // Extra headroom bits so popcount plus count cannot wrap before clamping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(logic [CNT_WIDTH-1:0] cnt,
                                                   logic [NUM_RD_PORTS-1:0] hits);
    logic [CNT_WIDTH+3:0] sum;
    sum = {4'b0, cnt} + (CNT_WIDTH+4)'($countones(hits));
    if (sum[CNT_WIDTH+3:CNT_WIDTH] != '0) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic                    fe_hit;
  logic [PortIdxWidth-1:0] fe_port;
  logic [ADDR_WIDTH-1:0]   fe_addr;
  logic [DATA_WIDTH-1:0]   fe_exp, fe_got;

  // Scan downwards so the lowest-indexed mismatching port is the one left selected.
  always_comb begin
    fe_hit  = 1'b0;
    fe_port = '0;
    fe_addr = '0;
    fe_exp  = '0;
    fe_got  = '0;
    for (int p = int'(NUM_RD_PORTS) - 1; p >= 0; p--) begin
      if (mis_s[p]) begin
        fe_hit  = 1'b1;
        fe_port = PortIdxWidth'(p);
        fe_addr = chk_addr[p];
        fe_exp  = chk_exp[p];
        fe_got  = chk_got[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_mismatch  <= '0;
      err_unwritten <= '0;
    end else begin
      err_mismatch  <= mis_s;
      err_unwritten <= unw_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      err_sticky      <= 1'b0;
      mismatch_cnt    <= '0;
      unwritten_cnt   <= '0;
      ecccorr_cnt     <= '0;
      eccderr_cnt     <= '0;
      first_err_valid <= 1'b0;
      first_err_port  <= '0;
      first_err_addr  <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else begin
      mismatch_cnt  <= sat_add(mismatch_cnt, mis_s);
      unwritten_cnt <= sat_add(unwritten_cnt, unw_s);
      ecccorr_cnt   <= sat_add(ecccorr_cnt, corr_s);
      eccderr_cnt   <= sat_add(eccderr_cnt, derr_s);
      if ((mis_s | unw_s) != '0) err_sticky <= 1'b1;
      if (!first_err_valid && fe_hit) begin
        first_err_valid <= 1'b1;
        first_err_port  <= fe_port;
        first_err_addr  <= fe_addr;
        first_err_exp   <= fe_exp;
        first_err_got   <= fe_got;
      end
    end
  end

endmodule

// File: tb/tb_mpram_intf_checker.sv
// Randomised scoreboard bench: two checkers (old-data and new-data read-during-write) snoop
// the same traffic; a byte-level reference model predicts every output, every cycle.
module tb_mpram_intf_checker;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NP    = 3;
  localparam int LAT   = 2;
  localparam int CW    = 2;
  localparam int NL    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NCYC  = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, wr_cs, clear_mem, clr_stats;
  logic [AW-1:0]      wr_addr;
  logic [NL-1:0]      wr_be;
  logic [DW-1:0]      wr_data;
  logic [NP-1:0]      rd_cs, ecccorr, eccderr;
  logic [NP*AW-1:0]   rd_addr;
  logic [NP*DW-1:0]   rd_data;

  logic [NP-1:0] o_mis [2];
  logic [NP-1:0] o_unw [2];
  logic          o_sticky [2];
  logic [CW-1:0] o_mc [2];
  logic [CW-1:0] o_uc [2];
  logic [CW-1:0] o_cc [2];
  logic [CW-1:0] o_dc [2];
  logic          o_fev [2];
  logic [2:0]    o_fep [2];
  logic [AW-1:0] o_fea [2];
  logic [DW-1:0] o_fee [2];
  logic [DW-1:0] o_feg [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mpram_intf_checker #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .NUM_RD_PORTS (NP),
      .RD_LATENCY   (LAT),
      .RDW_NEW      (d),
      .CNT_WIDTH    (CW)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .wr_cs           (wr_cs),
      .wr_addr         (wr_addr),
      .wr_be           (wr_be),
      .wr_data         (wr_data),
      .rd_cs           (rd_cs),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .ecccorr         (ecccorr),
      .eccderr         (eccderr),
      .clear_mem       (clear_mem),
      .clr_stats       (clr_stats),
      .err_mismatch    (o_mis[d]),
      .err_unwritten   (o_unw[d]),
      .err_sticky      (o_sticky[d]),
      .mismatch_cnt    (o_mc[d]),
      .unwritten_cnt   (o_uc[d]),
      .ecccorr_cnt     (o_cc[d]),
      .eccderr_cnt     (o_dc[d]),
      .first_err_valid (o_fev[d]),
      .first_err_port  (o_fep[d]),
      .first_err_addr  (o_fea[d]),
      .first_err_exp   (o_fee[d]),
      .first_err_got   (o_feg[d])
    );
  end

  typedef struct {
    int            edge_no;
    logic [NP-1:0] mis, unw;
    logic          sticky;
    logic [CW-1:0] mc, uc, cc, dc;
    logic          fev;
    logic [2:0]    fep;
    logic [AW-1:0] fea;
    logic [DW-1:0] fee, feg;
  } rec_t;

  typedef struct {
    int            due;
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] e0, e1;
    logic [NL-1:0] m0, m1;
  } infl_t;

  rec_t  q0[$], q1[$];
  rec_t  st [2];
  infl_t infl[$];

  // Reference shadow: one byte and one written flag per lane.
  logic [7:0] mb [DEPTH][NL];
  bit         ok [DEPTH][NL];

  // Results of reads returned this cycle, reported one cycle later.
  logic [NP-1:0] pm [2];
  logic [NP-1:0] pu [2];
  logic [NP-1:0] pcr [2];
  logic [NP-1:0] pdr [2];
  logic [AW-1:0] pa [NP];
  logic [DW-1:0] pe [2][NP];
  logic [DW-1:0] pg [NP];

  int checks = 0;
  int fails  = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic rec_t zero_rec();
    rec_t r;
    r.edge_no = 0; r.mis = '0; r.unw = '0; r.sticky = 1'b0;
    r.mc = '0; r.uc = '0; r.cc = '0; r.dc = '0;
    r.fev = 1'b0; r.fep = '0; r.fea = '0; r.fee = '0; r.feg = '0;
    return r;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] cnt, input logic [NP-1:0] v);
    int s;
    s = int'(cnt) + $countones(v);
    return (s > CMAX) ? CW'(CMAX) : CW'(s);
  endfunction

  function automatic void capture(input int a, input bit merge,
                                  output logic [DW-1:0] e, output logic [NL-1:0] m);
    e = '0;
    m = '0;
    for (int l = 0; l < NL; l++) begin
      if (merge && wr_cs && int'(wr_addr) == a && wr_be[l]) begin
        e[l*8 +: 8] = wr_data[l*8 +: 8];
        m[l] = 1'b1;
      end else if (ok[a][l]) begin
        e[l*8 +: 8] = mb[a][l];
        m[l] = 1'b1;
      end
    end
  endfunction

  function automatic void judge(input int d, input int p, input logic [DW-1:0] got,
                                input logic [DW-1:0] e, input logic [NL-1:0] m,
                                input bit de, input bit co);
    if (co) pcr[d][p] = 1'b1;
    if (de) pdr[d][p] = 1'b1;
    else if (m == '0) pu[d][p] = 1'b1;
    else begin
      for (int l = 0; l < NL; l++) begin
        if (m[l] && got[l*8 +: 8] != e[l*8 +: 8]) pm[d][p] = 1'b1;
      end
    end
  endfunction

  task automatic advance(input int d, input bit r, input bit cl, input int c);
    rec_t rec;
    if (r) st[d] = zero_rec();
    else begin
      st[d].mis = pm[d];
      st[d].unw = pu[d];
      if (cl) begin
        st[d].sticky = 1'b0;
        st[d].mc = '0; st[d].uc = '0; st[d].cc = '0; st[d].dc = '0;
        st[d].fev = 1'b0; st[d].fep = '0; st[d].fea = '0; st[d].fee = '0; st[d].feg = '0;
      end else begin
        st[d].mc = sat(st[d].mc, pm[d]);
        st[d].uc = sat(st[d].uc, pu[d]);
        st[d].cc = sat(st[d].cc, pcr[d]);
        st[d].dc = sat(st[d].dc, pdr[d]);
        if ((pm[d] | pu[d]) != '0) st[d].sticky = 1'b1;
        if (!st[d].fev) begin
          for (int p = 0; p < NP; p++) begin
            if (pm[d][p]) begin
              st[d].fev = 1'b1;
              st[d].fep = 3'(p);
              st[d].fea = pa[p];
              st[d].fee = pe[d][p];
              st[d].feg = pg[p];
              break;
            end
          end
        end
      end
    end
    rec = st[d];
    rec.edge_no = c;
    if (d == 0) q0.push_back(rec);
    else q1.push_back(rec);
  endtask

  task automatic respond(input infl_t e);
    logic [DW-1:0] got;
    int            bitpos;
    bit            de, co;
    got = $urandom;
    for (int l = 0; l < NL; l++) begin
      if (e.m0[l] || e.m1[l])
        got[l*8 +: 8] = ($urandom_range(0, 1) == 0) ? e.e0[l*8 +: 8] : e.e1[l*8 +: 8];
    end
    if ($urandom_range(0, 3) == 0) begin
      bitpos = $urandom_range(0, DW - 1);
      got[bitpos] = ~got[bitpos];
    end
    de = ($urandom_range(0, 9) == 0);
    co = ($urandom_range(0, 7) == 0);
    rd_data[e.port*DW +: DW] = got;
    eccderr[e.port] = de;
    ecccorr[e.port] = co;
    pa[e.port] = e.addr;
    pg[e.port] = got;
    pe[0][e.port] = e.e0;
    pe[1][e.port] = e.e1;
    judge(0, e.port, got, e.e0, e.m0, de, co);
    judge(1, e.port, got, e.e1, e.m1, de, co);
  endtask

  task automatic cmp(input string nm, input int d, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d edge %0d: got %0h want %0h", nm, d, edge_cnt, got, exp);
    end
  endtask

  task automatic compare(input int d, input rec_t r);
    cmp("err_mismatch", d, 64'(o_mis[d]), 64'(r.mis));
    cmp("err_unwritten", d, 64'(o_unw[d]), 64'(r.unw));
    cmp("err_sticky", d, 64'(o_sticky[d]), 64'(r.sticky));
    cmp("mismatch_cnt", d, 64'(o_mc[d]), 64'(r.mc));
    cmp("unwritten_cnt", d, 64'(o_uc[d]), 64'(r.uc));
    cmp("ecccorr_cnt", d, 64'(o_cc[d]), 64'(r.cc));
    cmp("eccderr_cnt", d, 64'(o_dc[d]), 64'(r.dc));
    cmp("first_err_valid", d, 64'(o_fev[d]), 64'(r.fev));
    cmp("first_err_port", d, 64'(o_fep[d]), 64'(r.fep));
    cmp("first_err_addr", d, 64'(o_fea[d]), 64'(r.fea));
    cmp("first_err_exp", d, 64'(o_fee[d]), 64'(r.fee));
    cmp("first_err_got", d, 64'(o_feg[d]), 64'(r.feg));
  endtask

  // Monitor: pops the expectation for the edge just taken and checks every output.
  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].edge_no < edge_cnt) begin
      fails++;
      $display("FAIL skipped_record dut0 edge %0d: got none want edge %0d", edge_cnt,
               q0[0].edge_no);
      void'(q0.pop_front());
    end
    while (q1.size() > 0 && q1[0].edge_no < edge_cnt) begin
      fails++;
      $display("FAIL skipped_record dut1 edge %0d: got none want edge %0d", edge_cnt,
               q1[0].edge_no);
      void'(q1.pop_front());
    end
    if (q0.size() > 0 && q0[0].edge_no == edge_cnt) compare(0, q0.pop_front());
    if (q1.size() > 0 && q1[0].edge_no == edge_cnt) compare(1, q1.pop_front());
  end

  initial begin
    rst = 1'b1; wr_cs = 1'b0; clear_mem = 1'b0; clr_stats = 1'b0;
    wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_cs = '0; rd_addr = '0; rd_data = '0; ecccorr = '0; eccderr = '0;
    st[0] = zero_rec();
    st[1] = zero_rec();
    for (int d = 0; d < 2; d++) begin
      pm[d] = '0; pu[d] = '0; pcr[d] = '0; pdr[d] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      pa[p] = '0; pg[p] = '0; pe[0][p] = '0; pe[1][p] = '0;
    end

    for (int c = 1; c <= NCYC; c++) begin
      bit            r, cl;
      int            a;
      logic [DW-1:0] e0, e1;
      logic [NL-1:0] m0, m1;
      infl_t         ent;

      r  = (c <= 3) || ($urandom_range(0, 149) == 0);
      cl = ($urandom_range(0, 24) == 0);
      rst = r;
      clr_stats = cl;

      advance(0, r, cl, c);
      advance(1, r, cl, c);

      rd_data = {$urandom, $urandom, $urandom};
      ecccorr = NP'($urandom);
      eccderr = NP'($urandom);
      for (int d = 0; d < 2; d++) begin
        pm[d] = '0; pu[d] = '0; pcr[d] = '0; pdr[d] = '0;
      end
      for (int i = infl.size() - 1; i >= 0; i--) begin
        if (infl[i].due == c && !r) respond(infl[i]);
        if (r || infl[i].due == c) infl.delete(i);
      end

      wr_cs     = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_be     = NL'($urandom);
      wr_data   = $urandom;
      clear_mem = ($urandom_range(0, 39) == 0);

      for (int p = 0; p < NP; p++) begin
        rd_cs[p] = ($urandom_range(0, 9) < 6);
        a = ($urandom_range(0, 1) == 0) ? int'(wr_addr) : $urandom_range(0, DEPTH - 1);
        rd_addr[p*AW +: AW] = AW'(a);
        if (!r && rd_cs[p]) begin
          capture(a, 1'b0, e0, m0);
          capture(a, 1'b1, e1, m1);
          ent.due = c + LAT; ent.port = p; ent.addr = AW'(a);
          ent.e0 = e0; ent.e1 = e1; ent.m0 = m0; ent.m1 = m1;
          infl.push_back(ent);
        end
      end

      if (r || clear_mem) begin
        for (int i = 0; i < DEPTH; i++)
          for (int l = 0; l < NL; l++) ok[i][l] = 1'b0;
      end
      if (!r && wr_cs) begin
        for (int l = 0; l < NL; l++) begin
          if (wr_be[l]) begin
            mb[wr_addr][l] = wr_data[l*8 +: 8];
            ok[wr_addr][l] = 1'b1;
          end
        end
      end

      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d records left want 0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
